vc_writeback_buffer: RTL and testbench

//  Drains dirty lines evicted from the 8-way victim cache to physical memory.

---
 rtl/vc_writeback_buffer.sv | 105 ++++++++++
 tb/tb_vc_writeback_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vc_writeback_buffer.sv
// vc_writeback_buffer: in-order FIFO draining dirty victim-cache lines to pmem, with coalescing and a combinational lookup.
module vc_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 12,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          evict_valid,
  output logic          evict_ready,
  input  logic [AW-1:0] evict_address,
  input  logic [DW-1:0] evict_data,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [DW-1:0] pmem_wdata,
  input  logic          pmem_resp,
  input  logic [AW-1:0] lookup_address,
  output logic          lookup_hit,
  output logic [DW-1:0] lookup_data,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, WRITE} state_e;
  state_e        state_q, state_d;
  logic          valid_q [DEPTH];
  logic          valid_d [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [AW-1:0] addr_d  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [DW-1:0] data_d  [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, coal_idx, lk;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, coal;
  assign evict_ready  = !reset && (count_q < CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign pmem_write   = (state_q == WRITE);
  assign pmem_address = {addr_q[head_q], 4'b0000};
  assign pmem_wdata   = data_q[head_q];
  assign push         = evict_valid && evict_ready;
  assign pop          = (state_q == WRITE) && pmem_resp;
  always_comb begin
    coal     = 1'b0;
    coal_idx = '0;
    // the head being written is frozen; a re-eviction of it must queue behind
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && addr_q[i] == evict_address && !(state_q == WRITE && PW'(i) == head_q)) begin
        coal     = 1'b1;
        coal_idx = PW'(i);
      end
  end
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push && coal)
      data_d[coal_idx] = evict_data;
    if (push && !coal) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = evict_address;
      data_d[tail_q]  = evict_data;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    count_d = count_q + CW'(push && !coal) - CW'(pop);
    state_d = (state_q == IDLE) ? ((count_q != '0) ? WRITE : IDLE) : (pop ? IDLE : WRITE);
  end
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk          = head_q;
    // walk oldest to youngest so the youngest match is the one left standing
    for (int i = 0; i < DEPTH; i++) begin
      lk = head_q + PW'(i);
      if (valid_q[lk] && addr_q[lk] == lookup_address) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lk];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '{default: 1'b0};
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_vc_writeback_buffer.sv
// tb_vc_writeback_buffer: directed self-checking bench for vc_writeback_buffer.
module tb_vc_writeback_buffer;
  logic          clk = 1'b0;
  logic          reset, evict_valid, evict_ready, pmem_write, pmem_resp, lookup_hit, empty;
  logic [11:0]   evict_address, lookup_address;
  logic [127:0]  evict_data, pmem_wdata, lookup_data;
  logic [15:0]   pmem_address;
  int            total = 0;
  int            bad = 0;
  vc_writeback_buffer dut (
    .clk(clk), .reset(reset), .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_address(evict_address), .evict_data(evict_data), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .lookup_address(lookup_address), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [11:0] a, input logic [127:0] d);
    evict_valid   = 1'b1;
    evict_address = a;
    evict_data    = d;
    cyc();
    evict_valid   = 1'b0;
  endtask
  task automatic drain(input string tag, input logic [15:0] a, input logic [127:0] d);
    for (int i = 0; i < 10 && !pmem_write; i++) cyc();
    chk({tag, "_wr"}, 128'(pmem_write), 128'd1);
    chk({tag, "_addr"}, 128'(pmem_address), 128'(a));
    chk({tag, "_data"}, pmem_wdata, d);
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    chk({tag, "_idle"}, 128'(pmem_write), 128'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; evict_valid = 1'b0; evict_address = '0; evict_data = '0;
    pmem_resp = 1'b0; lookup_address = '0;
    cyc();
    chk("rst_ready_low", 128'(evict_ready), 128'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_ready", 128'(evict_ready), 128'd1);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_write", 128'(pmem_write), 128'd0);
    chk("rst_hit", 128'(lookup_hit), 128'd0);
    push(12'h0A3, {8{16'h1111}});
    lookup_address = 12'h0A3;
    #1;
    chk("s2_empty", 128'(empty), 128'd0);
    chk("s2_hit", 128'(lookup_hit), 128'd1);
    chk("s2_ldata", lookup_data, {8{16'h1111}});
    chk("s2_idle", 128'(pmem_write), 128'd0);
    cyc();
    chk("s2_write", 128'(pmem_write), 128'd1);
    chk("s2_addr", 128'(pmem_address), 128'h0A30);
    chk("s2_wdata", pmem_wdata, {8{16'h1111}});
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    chk("s2_done_empty", 128'(empty), 128'd1);
    chk("s2_done_write", 128'(pmem_write), 128'd0);
    for (int i = 1; i <= 4; i++) push(12'h010 + 12'(i), {4{32'hA0 + 32'(i)}});
    chk("s3_full", 128'(evict_ready), 128'd0);
    evict_valid = 1'b1; evict_address = 12'h015; evict_data = {4{32'hA5}};
    cyc();
    chk("s3_stall", 128'(evict_ready), 128'd0);
    chk("s3_head", 128'(pmem_address), 128'h0110);
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    chk("s3_nobypass_ready", 128'(evict_ready), 128'd1);
    chk("s3_gap", 128'(pmem_write), 128'd0);
    cyc();
    evict_valid = 1'b0;
    chk("s3_refull", 128'(evict_ready), 128'd0);
    for (int i = 2; i <= 5; i++) drain("s3_drain", 16'h0100 + 16'(i << 4), {4{32'hA0 + 32'(i)}});
    chk("s3_empty", 128'(empty), 128'd1);
    push(12'h100, {4{32'h1001}});
    push(12'h200, {4{32'h200A}});
    chk("s4_inflight", 128'(pmem_address), 128'h1000);
    push(12'h200, {4{32'h200B}});
    lookup_address = 12'h200;
    #1;
    chk("s4_lookup", lookup_data, {4{32'h200B}});
    drain("s4_d0", 16'h1000, {4{32'h1001}});
    drain("s4_d1", 16'h2000, {4{32'h200B}});
    chk("s4_coalesced_empty", 128'(empty), 128'd1);
    push(12'h055, {4{32'h055A}});
    cyc();
    chk("s5_inflight", 128'(pmem_write), 128'd1);
    push(12'h055, {4{32'h055B}});
    lookup_address = 12'h055;
    #1;
    chk("s5_hit", 128'(lookup_hit), 128'd1);
    chk("s5_young", lookup_data, {4{32'h055B}});
    lookup_address = 12'h056;
    #1;
    chk("s5_miss_hit", 128'(lookup_hit), 128'd0);
    chk("s5_miss_data", lookup_data, 128'd0);
    drain("s5_d0", 16'h0550, {4{32'h055A}});
    drain("s5_d1", 16'h0550, {4{32'h055B}});
    chk("s5_empty", 128'(empty), 128'd1);
    push(12'h0AA, {4{32'h0AA0}});
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    chk("s6_idle_resp_empty", 128'(empty), 128'd0);
    chk("s6_idle_resp_write", 128'(pmem_write), 128'd1);
    push(12'h0BB, {4{32'h0BB0}});
    push(12'h0CC, {4{32'h0CC0}});
    chk("s6_stable_addr", 128'(pmem_address), 128'h0AA0);
    reset = 1'b1;
    cyc();
    chk("s6_rst_write", 128'(pmem_write), 128'd0);
    chk("s6_rst_empty", 128'(empty), 128'd1);
    chk("s6_rst_ready", 128'(evict_ready), 128'd0);
    reset = 1'b0;
    lookup_address = 12'h0BB;
    #1;
    chk("s6_ready", 128'(evict_ready), 128'd1);
    chk("s6_hit", 128'(lookup_hit), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
